// File: rtl/fmap_display_reader.sv
// fmap_display_reader: reads a captured grayscale feature map back from BRAM
// port B and streams it in raster order, with integer nearest-neighbour
// upscaling, as an 8-bit valid/ready pixel stream.
module fmap_display_reader #(
    parameter int unsigned FMAP_W     = 24,
    parameter int unsigned FMAP_H     = 24,
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int unsigned SCALE      = 2,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         frame_done,
    output logic         overrun,
    output logic         bram_en_b,
    output logic [11:0]  bram_addr_b,
    input  logic [255:0] bram_rddata_b,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [7:0]   m_data,
    output logic         m_sof,
    output logic         m_eol
);

    localparam int unsigned OUT_W = FMAP_W * SCALE;
    localparam int unsigned OUT_H = FMAP_H * SCALE;
    localparam int unsigned CW    = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int unsigned RW    = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NW1   = NW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Issue-side coordinates of the next read to be issued
    logic [CW-1:0] col_q;
    logic [SW-1:0] vrep_q;
    logic [RW-1:0] src_row_q;

    // Read-return pipeline: stage 0 coincides with bram_en_b
    logic [RD_LAT:0] vld_pipe_q;
    logic [RW-1:0]   row_pipe_q [RD_LAT+1];

    // Prefetch FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt_c;
    logic [NW-1:0] fifo_count_q, inflight_q, remain_c, count_nxt_c;
    logic [NW1-1:0] occ_c;

    // Output-side counters
    logic [SW-1:0] hrep_q, hrep_nxt_c;
    logic [XW-1:0] out_x_q, out_x_nxt_c;
    logic [YW-1:0] out_y_q, out_y_nxt_c;

    logic       fire_c, pop_c, wr_en_c, credit_ok_c;
    logic       issue_c, last_issue_c, overrun_set_c, last_beat_c;
    logic [7:0] sel_base_c, wr_data_c, head_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue_c) state_d = last_issue_c ? S_DRAIN : S_RUN;
            S_RUN:   if (issue_c && last_issue_c) state_d = S_DRAIN;
            S_DRAIN: if (last_beat_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: read issue, overrun detection, end-of-frame handshake
    always_comb begin
        issue_c       = 1'b0;
        overrun_set_c = 1'b0;
        last_beat_c   = 1'b0;
        case (state_q)
            S_IDLE: issue_c = start && credit_ok_c;
            S_RUN: begin
                issue_c       = credit_ok_c;
                overrun_set_c = start;
            end
            S_DRAIN: begin
                overrun_set_c = start;
                last_beat_c   = fire_c && (out_x_q == XW'(OUT_W - 1))
                                       && (out_y_q == YW'(OUT_H - 1));
            end
            default: ;
        endcase
    end

    assign last_issue_c = (src_row_q == RW'(FMAP_H - 1)) && (vrep_q == SW'(SCALE - 1))
                       && (col_q == CW'(FMAP_W - 1));

    // Datapath next values: handshake, FIFO occupancy, credit and head byte
    always_comb begin
        fire_c       = m_valid & m_ready;
        pop_c        = fire_c && (hrep_q == SW'(SCALE - 1));
        wr_en_c      = vld_pipe_q[RD_LAT];
        sel_base_c   = 8'({row_pipe_q[RD_LAT], 3'b000});
        wr_data_c    = bram_rddata_b[sel_base_c +: 8];
        remain_c     = fifo_count_q - NW'(pop_c);
        count_nxt_c  = remain_c + NW'(wr_en_c);
        // An entry popped this cycle frees its slot for a read decided this cycle
        occ_c        = NW1'(remain_c) + NW1'(inflight_q);
        credit_ok_c  = occ_c < NW1'(FIFO_DEPTH);
        rd_ptr_nxt_c = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        head_c       = (remain_c == '0) ? wr_data_c : fifo_mem[rd_ptr_nxt_c];

        hrep_nxt_c  = hrep_q;
        out_x_nxt_c = out_x_q;
        out_y_nxt_c = out_y_q;
        if (fire_c) begin
            hrep_nxt_c = pop_c ? '0 : hrep_q + SW'(1);
            if (out_x_q == XW'(OUT_W - 1)) begin
                out_x_nxt_c = '0;
                out_y_nxt_c = (out_y_q == YW'(OUT_H - 1)) ? '0 : out_y_q + YW'(1);
            end else begin
                out_x_nxt_c = out_x_q + XW'(1);
            end
        end
    end

    // Issue side: address generation with column/vertical-repeat/row wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_en_b   <= 1'b0;
            bram_addr_b <= BASE_ADDR;
            col_q       <= '0;
            vrep_q      <= '0;
            src_row_q   <= '0;
        end else begin
            bram_en_b <= issue_c;
            if (issue_c) begin
                bram_addr_b <= BASE_ADDR + 12'(col_q);
                if (col_q == CW'(FMAP_W - 1)) begin
                    col_q <= '0;
                    if (vrep_q == SW'(SCALE - 1)) begin
                        vrep_q    <= '0;
                        src_row_q <= (src_row_q == RW'(FMAP_H - 1)) ? '0 : src_row_q + RW'(1);
                    end else begin
                        vrep_q <= vrep_q + SW'(1);
                    end
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Byte-select pipeline that travels alongside each outstanding read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int k = 0; k <= int'(RD_LAT); k++) row_pipe_q[k] <= '0;
        end else begin
            vld_pipe_q    <= {vld_pipe_q[RD_LAT-1:0], issue_c};
            row_pipe_q[0] <= src_row_q;
            for (int k = 1; k <= int'(RD_LAT); k++) row_pipe_q[k] <= row_pipe_q[k-1];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_c) fifo_mem[wr_ptr_q] <= wr_data_c;
    end

    // FIFO pointers, occupancy and outstanding-read count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
        end else begin
            if (wr_en_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
            rd_ptr_q     <= rd_ptr_nxt_c;
            fifo_count_q <= count_nxt_c;
            inflight_q   <= inflight_q + NW'(issue_c) - NW'(wr_en_c);
        end
    end

    // Output stream registers: head byte, repeat counters and frame markers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            hrep_q  <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
        end else begin
            m_valid <= (count_nxt_c != '0);
            if (count_nxt_c != '0) m_data <= head_c;
            m_sof   <= (count_nxt_c != '0) && (out_x_nxt_c == '0) && (out_y_nxt_c == '0);
            m_eol   <= (count_nxt_c != '0) && (out_x_nxt_c == XW'(OUT_W - 1));
            hrep_q  <= hrep_nxt_c;
            out_x_q <= out_x_nxt_c;
            out_y_q <= out_y_nxt_c;
        end
    end

    // Status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            busy       <= (state_d != S_IDLE);
            frame_done <= last_beat_c;
            overrun    <= overrun | overrun_set_c;
        end
    end

endmodule

// File: tb/tb_fmap_display_reader.sv
// Testbench for fmap_display_reader: directed frames against a BRAM model,
// covering reset, full frames, backpressure, overrun, mid-frame reset and SCALE=1.
`timescale 1ns/1ps
module tb_fmap_display_reader;

    localparam int unsigned A_LAT = 2;
    localparam int unsigned B_LAT = 3;
    localparam int A_BEATS = 2304;
    localparam int B_BEATS = 576;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance A: default parameters
    logic         a_start = 1'b0, a_busy, a_done, a_ovr, a_en;
    logic [11:0]  a_addr;
    logic [255:0] a_rd;
    logic         a_valid, a_ready, a_sof, a_eol;
    logic [7:0]   a_data;

    // Instance B: SCALE=1, RD_LAT=3, FIFO_DEPTH=5
    logic         b_start = 1'b0, b_busy, b_done, b_ovr, b_en;
    logic [11:0]  b_addr;
    logic [255:0] b_rd;
    logic         b_valid, b_sof, b_eol;
    logic         b_ready = 1'b1;
    logic [7:0]   b_data;

    logic bp_mode   = 1'b0;
    logic ready_fix = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fmap_display_reader u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .frame_done(a_done),
        .overrun(a_ovr), .bram_en_b(a_en), .bram_addr_b(a_addr), .bram_rddata_b(a_rd),
        .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .m_sof(a_sof), .m_eol(a_eol)
    );

    fmap_display_reader #(.SCALE(1), .RD_LAT(B_LAT), .FIFO_DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .frame_done(b_done),
        .overrun(b_ovr), .bram_en_b(b_en), .bram_addr_b(b_addr), .bram_rddata_b(b_rd),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_sof(b_sof), .m_eol(b_eol)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // BRAM content: byte r of word c holds r*24+c (mod 256)
    function automatic logic [255:0] mk_word(input logic [11:0] addr);
        logic [255:0] w;
        w = {32{8'hAA}};
        if (addr < 12'd24)
            for (int r = 0; r < 24; r++) w[r*8 +: 8] = 8'((r * 24 + int'(addr)) % 256);
        return w;
    endfunction

    function automatic logic [31:0] exp_a(input int k);
        return 32'((((k / 96) * 24) + ((k % 48) / 2)) % 256);
    endfunction

    // BRAM models with fixed read latency, free-running across reset
    logic        a_p_en   [1:A_LAT];
    logic [11:0] a_p_addr [1:A_LAT];
    logic        b_p_en   [1:B_LAT];
    logic [11:0] b_p_addr [1:B_LAT];

    always @(posedge clk) begin
        a_p_en[1] <= a_en;  a_p_addr[1] <= a_addr;
        for (int i = 2; i <= int'(A_LAT); i++) begin
            a_p_en[i] <= a_p_en[i-1]; a_p_addr[i] <= a_p_addr[i-1];
        end
        b_p_en[1] <= b_en;  b_p_addr[1] <= b_addr;
        for (int i = 2; i <= int'(B_LAT); i++) begin
            b_p_en[i] <= b_p_en[i-1]; b_p_addr[i] <= b_p_addr[i-1];
        end
    end

    assign a_rd = a_p_en[A_LAT] ? mk_word(a_p_addr[A_LAT]) : {8{32'hDEADBEEF}};
    assign b_rd = b_p_en[B_LAT] ? mk_word(b_p_addr[B_LAT]) : {8{32'hDEADBEEF}};

    // Ready driver for instance A
    always @(posedge clk) begin
        #1;
        a_ready = bp_mode ? ($urandom_range(0, 9) < 3) : ready_fix;
    end

    // Monitor A
    int a_beat = 0, a_eol_cnt = 0, a_sof_cnt = 0, a_done_cnt = 0, a_rd_cnt = 0, a_occ = 0;
    int a_first_v = -1, a_first_en = -1, a_start_cyc = 0;
    logic a_prev_stall = 1'b0, a_ps_sof = 1'b0, a_ps_eol = 1'b0;
    logic [7:0] a_ps_data = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            a_occ        = 0;
            a_prev_stall = 1'b0;
        end else begin
            if (a_start && !a_busy) begin
                a_beat = 0; a_eol_cnt = 0; a_sof_cnt = 0; a_done_cnt = 0; a_rd_cnt = 0;
                a_first_v = -1; a_first_en = -1; a_start_cyc = cyc;
            end
            if (a_en) begin
                a_rd_cnt++;
                if (a_first_en < 0) a_first_en = cyc;
                a_occ++;
                check("credit_le8", 32'(a_occ <= 8), 1);
            end
            if (a_prev_stall) begin
                check("hold_valid", 32'(a_valid), 1);
                check("hold_data", 32'(a_data), 32'(a_ps_data));
                check("hold_sof", 32'(a_sof), 32'(a_ps_sof));
                check("hold_eol", 32'(a_eol), 32'(a_ps_eol));
            end
            if (a_valid && a_first_v < 0) a_first_v = cyc;
            if (a_valid && a_ready) begin
                check("a_data", 32'(a_data), exp_a(a_beat));
                check("a_sof", 32'(a_sof), 32'(a_beat == 0));
                check("a_eol", 32'(a_eol), 32'(a_beat % 48 == 47));
                if (a_eol) a_eol_cnt++;
                if (a_sof) a_sof_cnt++;
                if (a_beat % 2 == 1) a_occ--;
                a_beat++;
            end
            a_prev_stall = a_valid && !a_ready;
            a_ps_data    = a_data;
            a_ps_sof     = a_sof;
            a_ps_eol     = a_eol;
            if (a_done) a_done_cnt++;
        end
    end

    // Monitor B
    int b_beat = 0, b_eol_cnt = 0, b_bubbles = 0, b_done_cnt = 0, b_first_v = -1, b_start_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (b_start && !b_busy) begin
                b_beat = 0; b_eol_cnt = 0; b_bubbles = 0; b_done_cnt = 0;
                b_first_v = -1; b_start_cyc = cyc;
            end
            if (b_valid && b_first_v < 0) b_first_v = cyc;
            if (b_first_v >= 0 && b_beat < B_BEATS && !b_valid) b_bubbles++;
            if (b_valid && b_ready) begin
                check("b_data", 32'(b_data), 32'(b_beat % 256));
                check("b_sof", 32'(b_sof), 32'(b_beat == 0));
                check("b_eol", 32'(b_eol), 32'(b_beat % 24 == 23));
                if (b_eol) b_eol_cnt++;
                b_beat++;
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic pulse_a();
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic pulse_b();
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
    endtask

    task automatic wait_a_done(input int budget);
        int n = 0;
        while (a_done_cnt == 0 && n < budget) begin @(negedge clk); #1; n++; end
        check("a_done_timeout", 32'(a_done_cnt != 0), 1);
    endtask

    task automatic wait_a_beat(input int target, input int budget);
        int n = 0;
        while (a_beat < target && n < budget) begin @(negedge clk); #1; n++; end
        check("a_beat_timeout", 32'(a_beat >= target), 1);
    endtask

    task automatic check_a_frame(input string tag);
        check({tag, "_beats"}, 32'(a_beat), 32'(A_BEATS));
        check({tag, "_eol"}, 32'(a_eol_cnt), 48);
        check({tag, "_sof"}, 32'(a_sof_cnt), 1);
        check({tag, "_done"}, 32'(a_done_cnt), 1);
        check({tag, "_reads"}, 32'(a_rd_cnt), 1152);
        check({tag, "_busy"}, 32'(a_busy), 0);
    endtask

    initial begin
        // 1: reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_ovr", 32'(a_ovr), 0);
        check("rst_en", 32'(a_en), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_valid", 32'(a_valid), 0);
        check("rst_data", 32'(a_data), 0);
        check("rst_sof", 32'(a_sof), 0);
        check("rst_eol", 32'(a_eol), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            check("idle_no_read", 32'(a_en), 0);
        end

        // 2: full frame, m_ready held high
        pulse_a();
        wait_a_done(6000);
        repeat (5) @(negedge clk);
        #1;
        check_a_frame("t2");
        check("t2_first_en_lat", 32'(a_first_en - a_start_cyc), 1);
        check("t2_first_valid_lat", 32'(a_first_v - a_start_cyc), 4);
        check("t2_ovr", 32'(a_ovr), 0);

        // 3: random backpressure
        bp_mode = 1'b1;
        pulse_a();
        wait_a_done(20000);
        repeat (5) @(negedge clk);
        #1;
        check_a_frame("t3");
        bp_mode = 1'b0;

        // 4: second start mid-frame sets overrun and is otherwise ignored
        pulse_a();
        wait_a_beat(1000, 3000);
        pulse_a();
        #1;
        check("t4_ovr_set", 32'(a_ovr), 1);
        check("t4_busy", 32'(a_busy), 1);
        wait_a_done(6000);
        repeat (50) @(negedge clk);
        #1;
        check_a_frame("t4");
        check("t4_ovr_sticky", 32'(a_ovr), 1);

        // 5: asynchronous reset mid-frame, then a clean frame
        pulse_a();
        wait_a_beat(500, 3000);
        #1 rst = 1'b1;
        #1;
        check("t5_valid", 32'(a_valid), 0);
        check("t5_en", 32'(a_en), 0);
        check("t5_busy", 32'(a_busy), 0);
        check("t5_sof", 32'(a_sof), 0);
        check("t5_ovr_clr", 32'(a_ovr), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        pulse_a();
        wait_a_done(6000);
        repeat (5) @(negedge clk);
        #1;
        check_a_frame("t5");

        // 6: SCALE=1 instance, back-to-back stream
        pulse_b();
        begin : wait_b
            int n = 0;
            while (b_done_cnt == 0 && n < 3000) begin @(negedge clk); #1; n++; end
        end
        check("t6_done_timeout", 32'(b_done_cnt != 0), 1);
        repeat (5) @(negedge clk);
        #1;
        check("t6_beats", 32'(b_beat), 32'(B_BEATS));
        check("t6_eol", 32'(b_eol_cnt), 24);
        check("t6_bubbles", 32'(b_bubbles), 0);
        check("t6_done", 32'(b_done_cnt), 1);
        check("t6_first_valid_lat", 32'(b_first_v - b_start_cyc), 5);
        check("t6_ovr", 32'(b_ovr), 0);
        check("t6_busy", 32'(b_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, tests_run %0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
